// File: rtl/cpu_collector_pkg.sv
// ---------------------------------------------------------------------------
// cpu_collector_pkg
// Shared types and helpers for the cpu_collector receiver.
//   state_e        : collector FSM states
//   pick_t         : result of a round-robin search {found, idx}
//   next_lfsr()    : one step of the 16-bit stall LFSR
//   rr_pick()      : rotate-priority search of a valid vector from a pointer
// ---------------------------------------------------------------------------
package cpu_collector_pkg;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int IDX_W   = 5;
  localparam int MAX_CPU = 32;

  // Fibonacci form shifting right: taps 16,14,13,11 land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  function automatic logic [15:0] next_lfsr(input logic [15:0] s);
    logic fb;
    fb = ^(s & LFSR_TAP_MASK);
    return {fb, s[15:1]};
  endfunction

  // First set bit of vld at or after ptr, wrapping modulo n (n <= MAX_CPU).
  function automatic pick_t rr_pick(input logic [MAX_CPU-1:0] vld,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 n);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < MAX_CPU; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if ((k < n) && !p.found && vld[j[IDX_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = j[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/cpu_collector_rr_arb.sv
// ---------------------------------------------------------------------------
// cpu_collector_rr_arb
// Combinational rotate-priority arbiter: returns the first valid port found
// when searching upward from i_ptr and wrapping modulo CPU_NB.
//   i_vld   : per-port valid
//   i_ptr   : search start index (0..CPU_NB-1)
//   o_found : at least one port is valid
//   o_idx   : index of the selected port (meaningful when o_found)
// ---------------------------------------------------------------------------
module cpu_collector_rr_arb
  import cpu_collector_pkg::*;
#(
  parameter int CPU_NB = 4
) (
  input  logic [CPU_NB-1:0] i_vld,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic              o_found,
  output logic [IDX_W-1:0]  o_idx
);

  logic [MAX_CPU-1:0] w_vld_ext;
  pick_t              w_pick;

  assign w_vld_ext = MAX_CPU'(i_vld);
  assign w_pick    = rr_pick(w_vld_ext, i_ptr, CPU_NB);
  assign o_found   = w_pick.found;
  assign o_idx     = w_pick.idx;

endmodule

// File: rtl/cpu_collector.sv
// ---------------------------------------------------------------------------
// cpu_collector
// Receiving end of the cpu valid/ready interface. Grants one word at a time
// round-robin with optional LFSR backpressure, accumulates count, XOR
// checksum and last word, flags protocol violations and reports completion.
//
// State table:
//   SCAN  | searching for a valid port; may enter DONE when all cpus finish
//   GRANT | data_rdy high for exactly one cycle on the latched port
//   DONE  | all cpus finished and drained; all_done held until reset
//
// Ports:
//   clk, rst           : clock, async active-high reset
//   data_vld/data      : per-cpu valid and 64-bit payload
//   transactions_done  : per-cpu completion level
//   data_rdy           : per-cpu ready, registered, one-hot or zero
//   rx_count/checksum  : accepted transfer count and XOR of payloads
//   last_data/index    : most recently accepted payload and its port
//   protocol_error     : sticky violation flag
//   all_done           : level, high in DONE
// ---------------------------------------------------------------------------
module cpu_collector
  import cpu_collector_pkg::*;
#(
  parameter int          CPU_NB      = 4,
  parameter int          STALL_LEVEL = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CPU_NB-1:0]      data_vld,
  input  logic [CPU_NB-1:0][63:0] data,
  input  logic [CPU_NB-1:0]      transactions_done,
  output logic [CPU_NB-1:0]      data_rdy,
  output logic [31:0]            rx_count,
  output logic [63:0]            checksum,
  output logic [63:0]            last_data,
  output logic [4:0]             last_index,
  output logic                   protocol_error,
  output logic                   all_done
);

  state_e                  r_state, w_state_nxt;
  logic [CPU_NB-1:0]       r_rdy, w_rdy_nxt;
  logic [IDX_W-1:0]        r_gidx, w_gidx_nxt;
  logic [IDX_W-1:0]        r_ptr, w_ptr_nxt;
  logic [15:0]             r_lfsr;
  logic [31:0]             r_rx_count;
  logic [63:0]             r_checksum;
  logic [63:0]             r_last_data;
  logic [IDX_W-1:0]        r_last_index;
  logic                    r_err;
  logic [CPU_NB-1:0]       r_vld_q;
  logic [CPU_NB-1:0]       r_pend;
  logic [CPU_NB-1:0][63:0] r_data_q;

  logic                    w_found;
  logic [IDX_W-1:0]        w_pick;
  logic                    w_stall;
  logic                    w_g_vld;
  logic [63:0]             w_g_data;
  logic                    w_accept;
  logic                    w_withdraw;
  logic [CPU_NB-1:0]       w_xfer;
  logic                    w_err_stab;
  logic                    w_err_drop;
  logic                    w_err_done;

  cpu_collector_rr_arb #(
    .CPU_NB (CPU_NB)
  ) u_rr_arb (
    .i_vld   (data_vld),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_stall = ({28'd0, r_lfsr[3:0]} < 32'(STALL_LEVEL));
  assign w_xfer  = data_vld & r_rdy;

  // Mux out the latched grant port without a variable-width index.
  always_comb begin
    w_g_vld  = 1'b0;
    w_g_data = '0;
    for (int i = 0; i < CPU_NB; i++) begin
      if (r_gidx == IDX_W'(i)) begin
        w_g_vld  = data_vld[i];
        w_g_data = data[i];
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SCAN;
      r_rdy   <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= w_rdy_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy_nxt   = '0;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    w_accept    = 1'b0;
    w_withdraw  = 1'b0;
    case (r_state)
      SCAN: begin
        if (w_found && !w_stall) begin
          for (int i = 0; i < CPU_NB; i++) begin
            if (w_pick == IDX_W'(i)) w_rdy_nxt[i] = 1'b1;
          end
          w_gidx_nxt  = w_pick;
          w_state_nxt = GRANT;
        end else if ((&transactions_done) && (data_vld == '0)) begin
          w_state_nxt = DONE;
        end
      end
      GRANT: begin
        w_accept    = w_g_vld;
        w_withdraw  = !w_g_vld;
        w_ptr_nxt   = (r_gidx == IDX_W'(CPU_NB - 1)) ? '0 : r_gidx + 1'b1;
        w_state_nxt = SCAN;
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = SCAN;
      end
    endcase
  end

  // ---------------- Protocol checker ----------------
  // r_pend marks a valid that was seen and not consumed at the previous edge,
  // so a cpu presenting a fresh word right after an accept is not flagged.
  always_comb begin
    w_err_stab = 1'b0;
    w_err_drop = 1'b0;
    for (int i = 0; i < CPU_NB; i++) begin
      if (!r_rdy[i] && r_pend[i] && data_vld[i] && (data[i] != r_data_q[i]))
        w_err_stab = 1'b1;
      if (r_pend[i] && !data_vld[i] && !w_xfer[i])
        w_err_drop = 1'b1;
    end
  end

  assign w_err_done = (r_state == DONE) && ((data_vld & ~r_vld_q) != '0);

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr       <= LFSR_SEED;
      r_rx_count   <= '0;
      r_checksum   <= '0;
      r_last_data  <= '0;
      r_last_index <= '0;
      r_err        <= 1'b0;
      r_vld_q      <= '0;
      r_pend       <= '0;
      r_data_q     <= '0;
    end else begin
      r_lfsr   <= next_lfsr(r_lfsr);
      r_vld_q  <= data_vld;
      r_pend   <= data_vld & ~w_xfer;
      r_data_q <= data;
      if (w_accept) begin
        r_rx_count   <= r_rx_count + 32'd1;
        r_checksum   <= r_checksum ^ w_g_data;
        r_last_data  <= w_g_data;
        r_last_index <= r_gidx;
      end
      if (w_withdraw || w_err_stab || w_err_drop || w_err_done)
        r_err <= 1'b1;
    end
  end

  assign data_rdy       = r_rdy;
  assign rx_count       = r_rx_count;
  assign checksum       = r_checksum;
  assign last_data      = r_last_data;
  assign last_index     = r_last_index;
  assign protocol_error = r_err;
  assign all_done       = (r_state == DONE);

endmodule
